pipe_hazard_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core (fetch/decode/execute/mem/wb).

---
 rtl/pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central hazard sequencer for a 5-stage pipeline (fetch/decode/execute/mem/wb).
// It produces the execute-stage operand forwarding selects and the per-stage
// stall, bubble and flush controls for three hazard sources:
//   - load-use: a load in execute feeds the instruction in decode,
//   - data-memory wait states: the mem stage waits for dmem_ack,
//   - taken branches/jumps resolved in the mem stage.
// It holds no datapath values, only register numbers and control bits.
//
// Ports
//   clk, rst_n              core clock, synchronous active-low reset
//   dec_rs1_i/dec_rs2_i     source registers of the decode instruction
//   dec_use_rs1_i/_rs2_i    decode instruction really reads rs1/rs2
//   ex_rs1_i/ex_rs2_i       source registers of the execute instruction
//   ex_rd_i                 destination register in execute
//   ex_writeback_i          execute instruction writes a register
//   ex_mem_r_i              execute instruction is a load
//   mem_rd_i, mem_writeback_i  destination / write flag in mem
//   wb_rd_i, wb_writeback_i    destination / write flag in writeback
//   brnch_taken_i           mem-stage branch/jump resolved taken
//   dmem_req_i, dmem_ack_i  data-memory request / completion
//   fwd_a_sel_o/fwd_b_sel_o 00 regfile, 01 mem result, 10 wb result
//   stall_if_o, stall_dec_o, stall_mem_o   hold the named pipeline registers
//   bubble_ex_o             load a NOP into execute
//   flush_dec_o, flush_ex_o zero the control bits of decode/execute
//   pc_redirect_o           fetch takes the branch target
//   mem_timeout_o           sticky: a dmem wait exceeded MEM_TIMEOUT cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W       = 6,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned FLUSH_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] dec_rs1_i,
    input  logic [REG_W-1:0] dec_rs2_i,
    input  logic             dec_use_rs1_i,
    input  logic             dec_use_rs2_i,
    input  logic [REG_W-1:0] ex_rs1_i,
    input  logic [REG_W-1:0] ex_rs2_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_writeback_i,
    input  logic             ex_mem_r_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             mem_writeback_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_writeback_i,
    input  logic             brnch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             stall_if_o,
    output logic             stall_dec_o,
    output logic             bubble_ex_o,
    output logic             stall_mem_o,
    output logic             flush_dec_o,
    output logic             flush_ex_o,
    output logic             pc_redirect_o,
    output logic             mem_timeout_o
);

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam int unsigned RW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [CW-1:0] WAIT_MAX   = CW'(MEM_TIMEOUT);
    // Last REDIRECT count value: REDIRECT lasts FLUSH_CYC-1 cycles after the
    // branch cycle itself.
    localparam logic [RW-1:0] REDIR_LAST = RW'((FLUSH_CYC > 1) ? FLUSH_CYC - 2 : 0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [RW-1:0] redir_cnt_q, redir_cnt_d;
    logic          timeout_q, timeout_d;

    logic mem_stall;
    logic load_use;

    // Forwarding select for one execute source register; mem has priority
    // over wb because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        if (rs == '0)                         return 2'b00;
        else if (mem_writeback_i && mem_rd_i == rs) return 2'b01;
        else if (wb_writeback_i && wb_rd_i == rs)   return 2'b10;
        else                                  return 2'b00;
    endfunction

    assign mem_stall = dmem_req_i && !dmem_ack_i;

    assign load_use = ex_mem_r_i && ex_writeback_i && (ex_rd_i != '0) &&
                      ((dec_use_rs1_i && dec_rs1_i == ex_rd_i) ||
                       (dec_use_rs2_i && dec_rs2_i == ex_rd_i));

    // Next-state logic. RUN and MEM_WAIT share the same exits: a wait ends as
    // soon as the stall condition drops, and a branch held in mem during the
    // wait is taken on that same cycle. REDIRECT freezes while memory stalls
    // so the wrong-path instruction it is draining is still flushed.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        redir_cnt_d = redir_cnt_q;
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;

        if (mem_stall) begin
            if (wait_cnt_q == WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q;
                timeout_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                redir_cnt_d = '0;
                if (mem_stall)
                    state_d = ST_MEM_WAIT;
                else if (brnch_taken_i && FLUSH_CYC > 1)
                    state_d = ST_REDIRECT;
                else
                    state_d = ST_RUN;
            end
            ST_REDIRECT: begin
                if (!mem_stall) begin
                    if (redir_cnt_q == REDIR_LAST) begin
                        state_d     = ST_RUN;
                        redir_cnt_d = '0;
                    end else begin
                        redir_cnt_d = redir_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_RUN;
                redir_cnt_d = '0;
            end
        endcase
    end

    // Output decode, highest priority first; everything is held low while
    // reset is asserted.
    always_comb begin
        fwd_a_sel_o   = 2'b00;
        fwd_b_sel_o   = 2'b00;
        stall_if_o    = 1'b0;
        stall_dec_o   = 1'b0;
        bubble_ex_o   = 1'b0;
        stall_mem_o   = 1'b0;
        flush_dec_o   = 1'b0;
        flush_ex_o    = 1'b0;
        pc_redirect_o = 1'b0;
        mem_timeout_o = 1'b0;

        if (rst_n) begin
            fwd_a_sel_o   = fwd_sel(ex_rs1_i);
            fwd_b_sel_o   = fwd_sel(ex_rs2_i);
            mem_timeout_o = timeout_q;

            if (mem_stall) begin
                stall_if_o  = 1'b1;
                stall_dec_o = 1'b1;
                stall_mem_o = 1'b1;
            end else if (state_q != ST_REDIRECT && brnch_taken_i) begin
                // The branch squashes the load-use consumer, so no bubble.
                pc_redirect_o = 1'b1;
                flush_dec_o   = 1'b1;
                flush_ex_o    = 1'b1;
            end else if (state_q == ST_REDIRECT) begin
                flush_dec_o = 1'b1;
            end else if (load_use) begin
                // Self-clearing: next cycle the load sits in mem and forwarding
                // covers the dependency.
                stall_if_o  = 1'b1;
                stall_dec_o = 1'b1;
                bubble_ex_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them
        // update together from the values sampled at this edge.
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            redir_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. A behavioural model tracks the
// length of the current memory wait, the number of wrong-path flush cycles
// still owed and the sticky timeout, and derives the expected outputs every
// cycle. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W       = 6;
    localparam int MEM_TIMEOUT = 255;
    localparam int FLUSH_CYC   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] dec_rs1, dec_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             dec_use_rs1, dec_use_rs2, ex_writeback, ex_mem_r;
    logic             mem_writeback, wb_writeback, brnch_taken, dmem_req, dmem_ack;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall_if, stall_dec, bubble_ex, stall_mem;
    logic             flush_dec, flush_ex, pc_redirect, mem_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state
    int m_wait_len  = 0;
    int m_redir_left = 0;
    bit m_timeout   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
        .dec_use_rs1_i(dec_use_rs1), .dec_use_rs2_i(dec_use_rs2),
        .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
        .ex_writeback_i(ex_writeback), .ex_mem_r_i(ex_mem_r),
        .mem_rd_i(mem_rd), .mem_writeback_i(mem_writeback),
        .wb_rd_i(wb_rd), .wb_writeback_i(wb_writeback),
        .brnch_taken_i(brnch_taken), .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
        .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel),
        .stall_if_o(stall_if), .stall_dec_o(stall_dec), .bubble_ex_o(bubble_ex),
        .stall_mem_o(stall_mem), .flush_dec_o(flush_dec), .flush_ex_o(flush_ex),
        .pc_redirect_o(pc_redirect), .mem_timeout_o(mem_timeout)
    );

    // Output vector layout: {fwd_a, fwd_b, stall_if, stall_dec, bubble_ex,
    // stall_mem, flush_dec, flush_ex, pc_redirect, mem_timeout}
    function automatic logic [11:0] dut_vec();
        return {fwd_a_sel, fwd_b_sel, stall_if, stall_dec, bubble_ex, stall_mem,
                flush_dec, flush_ex, pc_redirect, mem_timeout};
    endfunction

    function automatic logic [1:0] model_fwd(input logic [REG_W-1:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_writeback && mem_rd == rs) return 2'b01;
        if (wb_writeback && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_vec();
        bit s, lu;
        logic [7:0] ctl;   // stall_if, stall_dec, bubble, stall_mem, flush_dec, flush_ex, redirect, timeout
        if (!rst_n) return 12'h000;
        s  = dmem_req && !dmem_ack;
        lu = ex_mem_r && ex_writeback && ex_rd != 0 &&
             ((dec_use_rs1 && dec_rs1 == ex_rd) || (dec_use_rs2 && dec_rs2 == ex_rd));
        ctl = 8'b0;
        if (s)                                ctl = 8'b1101_0000;
        else if (m_redir_left == 0 && brnch_taken) ctl = 8'b0000_1110;
        else if (m_redir_left > 0)            ctl = 8'b0000_1000;
        else if (lu)                          ctl = 8'b1110_0000;
        ctl[0] = m_timeout;
        return {model_fwd(ex_rs1), model_fwd(ex_rs2), ctl};
    endfunction

    // Advance the model across one rising edge using the inputs of that cycle.
    task automatic model_clock();
        bit s;
        if (!rst_n) begin
            m_wait_len = 0; m_redir_left = 0; m_timeout = 0;
            return;
        end
        s = dmem_req && !dmem_ack;
        if (s) begin
            m_wait_len++;
            if (m_wait_len > MEM_TIMEOUT) m_timeout = 1;
        end else begin
            m_wait_len = 0;
        end
        if (m_redir_left > 0) begin
            if (!s) m_redir_left--;
        end else if (!s && brnch_taken) begin
            m_redir_left = FLUSH_CYC - 1;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then clock the model.
    task automatic step(input string tag);
        @(negedge clk);
        check(tag, dut_vec(), model_vec());
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_writeback = 0; ex_mem_r = 0;
        mem_rd = 0; mem_writeback = 0; wb_rd = 0; wb_writeback = 0;
        brnch_taken = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        // Reset with hazard-generating inputs active: outputs must stay low.
        idle_inputs();
        rst_n = 0;
        dmem_req = 1; brnch_taken = 1; ex_rs1 = 3; mem_rd = 3; mem_writeback = 1;
        step("reset_hold");
        step("reset_hold2");
        @(negedge clk);
        check("reset_outputs", dut_vec(), 12'h000);
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        step("idle");

        // Load-use: lw x5 in ex, add x6,x5,x1 in decode.
        ex_mem_r = 1; ex_writeback = 1; ex_rd = 5; dec_rs1 = 5; dec_use_rs1 = 1;
        dec_rs2 = 1; dec_use_rs2 = 1;
        @(negedge clk);
        check("lu_stall", dut_vec(), 12'b00_00_1110_0000);
        @(posedge clk); model_clock(); #1;
        // Load now in mem, consumer in ex.
        idle_inputs();
        ex_rs1 = 5; ex_rs2 = 1; mem_rd = 5; mem_writeback = 1;
        @(negedge clk);
        check("lu_forward", dut_vec(), 12'b01_00_0000_0000);
        @(posedge clk); model_clock(); #1;

        // Forwarding priority and x0.
        idle_inputs();
        mem_rd = 3; mem_writeback = 1; wb_rd = 3; wb_writeback = 1; ex_rs2 = 3;
        @(negedge clk);
        check("fwd_b_mem_prio", dut_vec(), 12'b00_01_0000_0000);
        @(posedge clk); model_clock(); #1;
        ex_rs2 = 0; mem_rd = 0; ex_rs1 = 3;
        @(negedge clk);
        check("fwd_x0_and_wb", dut_vec(), 12'b10_00_0000_0000);
        @(posedge clk); model_clock(); #1;

        // dmem wait of 4 cycles.
        idle_inputs();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dmem_wait_stall", dut_vec(), 12'b00_00_1101_0000);
            @(posedge clk); model_clock(); #1;
        end
        dmem_ack = 1;
        @(negedge clk);
        check("dmem_ack_cycle", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;
        idle_inputs();
        @(negedge clk);
        check("dmem_after_ack", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;

        // Branch with simultaneous load-use.
        ex_mem_r = 1; ex_writeback = 1; ex_rd = 7; dec_rs2 = 7; dec_use_rs2 = 1;
        brnch_taken = 1;
        @(negedge clk);
        check("branch_over_lu", dut_vec(), 12'b00_00_0000_1110);
        @(posedge clk); model_clock(); #1;
        idle_inputs();
        @(negedge clk);
        check("branch_drain", dut_vec(), 12'b00_00_0000_1000);
        @(posedge clk); model_clock(); #1;
        @(negedge clk);
        check("branch_done", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;

        // Branch held in mem during a wait is taken on the ack cycle.
        dmem_req = 1; brnch_taken = 1;
        step("br_wait1");
        step("br_wait2");
        dmem_ack = 1;
        @(negedge clk);
        check("br_on_ack", dut_vec(), 12'b00_00_0000_1110);
        @(posedge clk); model_clock(); #1;
        idle_inputs();
        step("br_on_ack_drain");
        step("br_on_ack_done");

        // Timeout: 255 wait cycles are fine, the 256th sets the sticky flag.
        dmem_req = 1;
        repeat (MEM_TIMEOUT) step("timeout_wait");
        check_bit("timeout_not_yet", mem_timeout, 1'b0);
        step("timeout_wait_last");
        check_bit("timeout_set", mem_timeout, 1'b1);
        dmem_ack = 1;
        step("timeout_ack");
        idle_inputs();
        step("timeout_sticky");
        check_bit("timeout_still_set", mem_timeout, 1'b1);
        rst_n = 0;
        step("timeout_reset");
        rst_n = 1;
        @(negedge clk);
        check("after_timeout_reset", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;

        // Reset during MEM_WAIT and during REDIRECT discards the operation.
        dmem_req = 1;
        step("rst_wait1");
        step("rst_wait2");
        rst_n = 0;
        step("rst_in_wait");
        rst_n = 1; dmem_req = 0;
        @(negedge clk);
        check("after_wait_reset", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;
        brnch_taken = 1;
        step("rst_redir_br");
        brnch_taken = 0; rst_n = 0;
        step("rst_in_redirect");
        rst_n = 1;
        @(negedge clk);
        check("after_redirect_reset", dut_vec(), 12'h000);
        @(posedge clk); model_clock(); #1;

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            dec_rs1       = REG_W'($urandom_range(0, 7));
            dec_rs2       = REG_W'($urandom_range(0, 7));
            dec_use_rs1   = 1'($urandom);
            dec_use_rs2   = 1'($urandom);
            ex_rs1        = REG_W'($urandom_range(0, 7));
            ex_rs2        = REG_W'($urandom_range(0, 7));
            ex_rd         = REG_W'($urandom_range(0, 7));
            ex_writeback  = 1'($urandom);
            ex_mem_r      = ($urandom_range(0, 2) == 0);
            mem_rd        = REG_W'($urandom_range(0, 7));
            mem_writeback = 1'($urandom);
            wb_rd         = REG_W'($urandom_range(0, 7));
            wb_writeback  = 1'($urandom);
            brnch_taken   = ($urandom_range(0, 5) == 0);
            if (dmem_req && !dmem_ack) begin
                dmem_ack = ($urandom_range(0, 2) == 0);
            end else begin
                dmem_req = ($urandom_range(0, 3) == 0);
                dmem_ack = dmem_req && ($urandom_range(0, 2) == 0);
            end
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
